// File: rtl/id_stage.sv
// RV32I decode stage: decodes the IF entry and holds it in a one-entry output register
// toward EX, with valid/ack back-pressure and flush.
module id_stage #(
    parameter bit SUPPORT_FENCE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        ack_o,
    output logic        valid_o,
    input  logic        ack_i,
    output logic [31:0] pc_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        we_o,
    output logic [31:0] imm_o,
    output logic [3:0]  class_o,
    output logic [2:0]  funct3_o,
    output logic        funct7b5_o,
    output logic        illegal_o
);
    localparam logic [3:0] CLS_LUI     = 4'd0;
    localparam logic [3:0] CLS_AUIPC   = 4'd1;
    localparam logic [3:0] CLS_JAL     = 4'd2;
    localparam logic [3:0] CLS_JALR    = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_LOAD    = 4'd5;
    localparam logic [3:0] CLS_STORE   = 4'd6;
    localparam logic [3:0] CLS_OP_IMM  = 4'd7;
    localparam logic [3:0] CLS_OP      = 4'd8;
    localparam logic [3:0] CLS_FENCE   = 4'd9;
    localparam logic [3:0] CLS_SYSTEM  = 4'd10;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    // Entry k holds the opcode of class k, so a table hit index is the class code.
    localparam int N_OPC = 11;
    localparam logic [N_OPC-1:0][6:0] OPCODE_TABLE = {
        7'b1110011, 7'b0001111, 7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
        7'b1100011, 7'b1100111, 7'b1101111, 7'b0010111, 7'b0110111
    };

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_field;
    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign rd_field = instr_i[11:7];

    logic [N_OPC-1:0] opc_hit;
    genvar gi;
    generate
        for (gi = 0; gi < N_OPC; gi++) begin : g_opc
            assign opc_hit[gi] = (opcode == OPCODE_TABLE[gi]);
        end
    endgenerate

    logic [3:0] opc_class;
    always_comb begin
        opc_class = CLS_ILLEGAL;
        for (int k = 0; k < N_OPC; k++) begin
            if (opc_hit[k]) opc_class = 4'(k);
        end
    end

    logic legal;
    always_comb begin
        legal = |opc_hit;
        case (opc_class)
            CLS_JALR:   if (funct3 != 3'd0) legal = 1'b0;
            CLS_BRANCH: if (funct3 == 3'd2 || funct3 == 3'd3) legal = 1'b0;
            CLS_LOAD:   if (funct3 == 3'd3 || funct3 >= 3'd6) legal = 1'b0;
            CLS_STORE:  if (funct3 > 3'd2) legal = 1'b0;
            CLS_OP_IMM: if ((funct3 == 3'd1 && funct7 != 7'h00) ||
                            (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20)) legal = 1'b0;
            CLS_OP:     if ((funct7 != 7'h00 && funct7 != 7'h20) ||
                            (funct7 == 7'h20 && funct3 != 3'd0 && funct3 != 3'd5)) legal = 1'b0;
            CLS_FENCE:  if (!SUPPORT_FENCE) legal = 1'b0;
            default: ;
        endcase
    end

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    logic [3:0]  class_next;
    logic [31:0] imm_next;
    logic [4:0]  rs1_next, rs2_next, rd_next;
    logic        we_next;
    logic        use_rs1, use_rs2, writes_rd;
    always_comb begin
        class_next = legal ? opc_class : CLS_ILLEGAL;
        imm_next   = '0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        writes_rd  = 1'b0;
        case (class_next)
            CLS_LUI, CLS_AUIPC: begin imm_next = imm_u; writes_rd = 1'b1; end
            CLS_JAL:    begin imm_next = imm_j; writes_rd = 1'b1; end
            CLS_JALR, CLS_LOAD, CLS_OP_IMM: begin
                imm_next  = imm_i;
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
            end
            CLS_BRANCH: begin imm_next = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            CLS_STORE:  begin imm_next = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            CLS_OP:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1; end
            CLS_SYSTEM: imm_next = imm_i;
            default: ;
        endcase
        we_next  = writes_rd && (rd_field != 5'd0);
        rd_next  = we_next ? rd_field : 5'd0;
        rs1_next = use_rs1 ? instr_i[19:15] : 5'd0;
        rs2_next = use_rs2 ? instr_i[24:20] : 5'd0;
    end

    logic        valid_reg;
    logic [31:0] pc_reg, imm_reg;
    logic [4:0]  rs1_reg, rs2_reg, rd_reg;
    logic        we_reg, funct7b5_reg, illegal_reg;
    logic [3:0]  class_reg;
    logic [2:0]  funct3_reg;

    assign ack_o = valid_i & (~valid_reg | ack_i) & ~flush_i & ~rst_i;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid_reg    <= 1'b0;
            pc_reg       <= '0;
            imm_reg      <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            we_reg       <= 1'b0;
            class_reg    <= '0;
            funct3_reg   <= '0;
            funct7b5_reg <= 1'b0;
            illegal_reg  <= 1'b0;
        end else if (flush_i) begin
            valid_reg <= 1'b0;
        end else if (ack_o) begin
            valid_reg    <= 1'b1;
            pc_reg       <= pc_i;
            imm_reg      <= imm_next;
            rs1_reg      <= rs1_next;
            rs2_reg      <= rs2_next;
            rd_reg       <= rd_next;
            we_reg       <= we_next;
            class_reg    <= class_next;
            funct3_reg   <= funct3;
            funct7b5_reg <= instr_i[30];
            illegal_reg  <= ~legal;
        end else if (ack_i) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid_o    = valid_reg;
    assign pc_o       = pc_reg;
    assign imm_o      = imm_reg;
    assign rs1_o      = rs1_reg;
    assign rs2_o      = rs2_reg;
    assign rd_o       = rd_reg;
    assign we_o       = we_reg;
    assign class_o    = class_reg;
    assign funct3_o   = funct3_reg;
    assign funct7b5_o = funct7b5_reg;
    assign illegal_o  = illegal_reg;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: decode vector table, hand-written handshake sequences and a
// randomized run against a behavioural decode/handshake model.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst_i, flush_i, valid_i, ack_i;
    logic [31:0] instr_i, pc_i;
    logic        ack_o, valid_o, we_o, funct7b5_o, illegal_o;
    logic [31:0] pc_o, imm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [3:0]  class_o;
    logic [2:0]  funct3_o;
    logic        nf_ack, nf_valid, nf_we, nf_f7b5, nf_illegal;
    logic [31:0] nf_pc, nf_imm;
    logic [4:0]  nf_rs1, nf_rs2, nf_rd;
    logic [3:0]  nf_class;
    logic [2:0]  nf_f3;

    always #5 clk = ~clk;

    id_stage #(.SUPPORT_FENCE(1'b1)) dut (
        .clk(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .instr_i(instr_i),
        .pc_i(pc_i), .ack_o(ack_o), .valid_o(valid_o), .ack_i(ack_i), .pc_o(pc_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .we_o(we_o), .imm_o(imm_o),
        .class_o(class_o), .funct3_o(funct3_o), .funct7b5_o(funct7b5_o), .illegal_o(illegal_o)
    );

    id_stage #(.SUPPORT_FENCE(1'b0)) dut_nf (
        .clk(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .instr_i(instr_i),
        .pc_i(pc_i), .ack_o(nf_ack), .valid_o(nf_valid), .ack_i(ack_i), .pc_o(nf_pc),
        .rs1_o(nf_rs1), .rs2_o(nf_rs2), .rd_o(nf_rd), .we_o(nf_we), .imm_o(nf_imm),
        .class_o(nf_class), .funct3_o(nf_f3), .funct7b5_o(nf_f7b5), .illegal_o(nf_illegal)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  cls;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic        we, ill;
    } vec_t;

    typedef struct {
        logic [3:0]  cls;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic        we, ill;
        logic [2:0]  f3;
        logic        f7b5;
    } dec_t;

    typedef enum {F_N, F_I, F_S, F_B, F_U, F_J} fmt_e;

    // Decode straight from the ISA rules: classify, pick a format, build the immediate arithmetically.
    function automatic dec_t ref_decode(input logic [31:0] ins, input bit fence_ok);
        dec_t d;
        int   f3, f7, s, cls;
        fmt_e fmt;
        bit   r1, r2, wr, ok;
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        s = ins;
        fmt = F_N; r1 = 0; r2 = 0; wr = 0; ok = 1; cls = 15;
        case (ins[6:0])
            7'b0110111: begin cls = 0;  fmt = F_U; wr = 1; end
            7'b0010111: begin cls = 1;  fmt = F_U; wr = 1; end
            7'b1101111: begin cls = 2;  fmt = F_J; wr = 1; end
            7'b1100111: begin cls = 3;  fmt = F_I; r1 = 1; wr = 1; ok = (f3 == 0); end
            7'b1100011: begin cls = 4;  fmt = F_B; r1 = 1; r2 = 1; ok = !(f3 inside {2, 3}); end
            7'b0000011: begin cls = 5;  fmt = F_I; r1 = 1; wr = 1; ok = !(f3 inside {3, 6, 7}); end
            7'b0100011: begin cls = 6;  fmt = F_S; r1 = 1; r2 = 1; ok = (f3 <= 2); end
            7'b0010011: begin
                cls = 7; fmt = F_I; r1 = 1; wr = 1;
                ok = !((f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {0, 32})));
            end
            7'b0110011: begin
                cls = 8; r1 = 1; r2 = 1; wr = 1;
                ok = (f7 == 0) || (f7 == 32 && (f3 inside {0, 5}));
            end
            7'b0001111: begin cls = 9;  ok = fence_ok; end
            7'b1110011: begin cls = 10; fmt = F_I; end
            default: ok = 0;
        endcase
        d.f3 = ins[14:12];
        d.f7b5 = ins[30];
        if (!ok) begin
            d.cls = 4'd15; d.imm = 0; d.rd = 0; d.rs1 = 0; d.rs2 = 0; d.we = 0; d.ill = 1;
            return d;
        end
        d.cls = 4'(cls);
        d.ill = 0;
        case (fmt)
            F_I: d.imm = 32'(s >>> 20);
            F_S: d.imm = 32'(((s >>> 25) <<< 5) | int'(ins[11:7]));
            F_B: d.imm = 32'(((s >>> 31) <<< 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1));
            F_U: d.imm = ins & 32'hFFFFF000;
            F_J: d.imm = 32'(((s >>> 31) <<< 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1));
            default: d.imm = 0;
        endcase
        d.we  = wr && (ins[11:7] != 0);
        d.rd  = d.we ? ins[11:7] : 5'd0;
        d.rs1 = r1 ? ins[19:15] : 5'd0;
        d.rs2 = r2 ? ins[24:20] : 5'd0;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:  r[6:0] = 7'b0110111;
            1:  r[6:0] = 7'b0010111;
            2:  r[6:0] = 7'b1101111;
            3:  r[6:0] = 7'b1100111;
            4:  r[6:0] = 7'b1100011;
            5:  r[6:0] = 7'b0000011;
            6:  r[6:0] = 7'b0100011;
            7:  r[6:0] = 7'b0010011;
            8:  r[6:0] = 7'b0110011;
            9:  r[6:0] = 7'b0001111;
            10: r[6:0] = 7'b1110011;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[17];
    dec_t m_ent;
    logic [31:0] m_pc;
    bit m_valid, exp_ack;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h00500093, 4'd7,  32'h00000005, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 4'd4,  32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        vecs[2]  = '{32'h123452B7, 4'd0,  32'h12345000, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0};
        vecs[3]  = '{32'h00000000, 4'd15, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1};
        vecs[4]  = '{32'hFFFFFFFF, 4'd15, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1};
        vecs[5]  = '{32'h40001033, 4'd15, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1};
        vecs[6]  = '{32'h0000000F, 4'd9,  32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        vecs[7]  = '{32'h402081B3, 4'd8,  32'h00000000, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0};
        vecs[8]  = '{32'hFE20AE23, 4'd6,  32'hFFFFFFFC, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0};
        vecs[9]  = '{32'h008000EF, 4'd2,  32'h00000008, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0};
        vecs[10] = '{32'h00008067, 4'd3,  32'h00000000, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0};
        vecs[11] = '{32'h00009067, 4'd15, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1};
        vecs[12] = '{32'hFFF12283, 4'd5,  32'hFFFFFFFF, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0};
        vecs[13] = '{32'h80000397, 4'd1,  32'h80000000, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0};
        vecs[14] = '{32'h00000073, 4'd10, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        vecs[15] = '{32'h4030D093, 4'd7,  32'h00000403, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0};
        vecs[16] = '{32'h40309093, 4'd15, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1};

        // Reset with an entry offered: nothing may be accepted.
        rst_i = 1; flush_i = 0; valid_i = 1; ack_i = 0;
        instr_i = 32'h00500093; pc_i = 32'h100;
        step(); step();
        chk("rst_ack", ack_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_class", class_o, 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_pc", pc_o, 0);
        rst_i = 0;
        #1 chk("first_ack", ack_o, 1);
        step();
        chk("first_valid", valid_o, 1);
        chk("first_class", class_o, 7);
        chk("first_rd", rd_o, 1);
        chk("first_rs1", rs1_o, 0);
        chk("first_imm", imm_o, 32'h5);
        chk("first_we", we_o, 1);
        chk("first_pc", pc_o, 32'h100);
        chk("first_ack_held", ack_o, 0);

        // Decode table, issued back-to-back with EX always ready.
        for (int i = 0; i < 17; i++) begin
            ack_i = 1; valid_i = 1; instr_i = vecs[i].instr; pc_i = 32'h200 + 32'(4 * i);
            #1 chk("vec_ack", ack_o, 1);
            step();
            valid_i = 0;
            $display("txn vec %0d instr=%08h class=%0d imm=%08h rd=%0d", i, vecs[i].instr, class_o, imm_o, rd_o);
            chk("vec_valid", valid_o, 1);
            chk("vec_pc", pc_o, 32'h200 + 32'(4 * i));
            chk("vec_class", class_o, vecs[i].cls);
            chk("vec_imm", imm_o, vecs[i].imm);
            chk("vec_rd", rd_o, vecs[i].rd);
            chk("vec_rs1", rs1_o, vecs[i].rs1);
            chk("vec_rs2", rs2_o, vecs[i].rs2);
            chk("vec_we", we_o, vecs[i].we);
            chk("vec_illegal", illegal_o, vecs[i].ill);
            chk("vec_nofence_class", nf_class, (vecs[i].cls == 4'd9) ? 4'd15 : vecs[i].cls);
            chk("vec_nofence_illegal", nf_illegal, (vecs[i].cls == 4'd9) ? 1'b1 : vecs[i].ill);
        end

        // Drain, then stall two cycles with three entries queued up in IF.
        step();
        chk("drain_valid", valid_o, 0);
        ack_i = 0; valid_i = 1; instr_i = 32'h00500093; pc_i = 32'h300;
        #1 chk("stall_first_ack", ack_o, 1);
        step();
        instr_i = 32'h123452B7; pc_i = 32'h304;
        for (int s = 0; s < 2; s++) begin
            #1;
            chk("stall_ack", ack_o, 0);
            chk("stall_valid", valid_o, 1);
            chk("stall_pc", pc_o, 32'h300);
            chk("stall_class", class_o, 7);
            chk("stall_imm", imm_o, 32'h5);
            step();
        end
        ack_i = 1;
        #1 chk("resume_ack", ack_o, 1);
        step();
        chk("b2b_pc1", pc_o, 32'h304);
        chk("b2b_class1", class_o, 0);
        chk("b2b_valid1", valid_o, 1);
        instr_i = 32'h402081B3; pc_i = 32'h308;
        #1 chk("b2b_ack2", ack_o, 1);
        step();
        chk("b2b_pc2", pc_o, 32'h308);
        chk("b2b_valid2", valid_o, 1);
        chk("b2b_class2", class_o, 8);

        // Flush while holding an entry and IF offering another.
        ack_i = 0; flush_i = 1; valid_i = 1; instr_i = 32'h008000EF; pc_i = 32'h400;
        #1 chk("flush_ack", ack_o, 0);
        step();
        chk("flush_valid", valid_o, 0);
        flush_i = 0;
        #1 chk("post_flush_ack", ack_o, 1);
        step();
        chk("post_flush_valid", valid_o, 1);
        chk("post_flush_pc", pc_o, 32'h400);
        chk("post_flush_class", class_o, 2);
        valid_i = 0;

        // Randomized run from a fresh reset against the model.
        rst_i = 1;
        step();
        rst_i = 0;
        m_valid = 0;
        for (int c = 0; c < 500; c++) begin
            valid_i = ($urandom_range(0, 9) < 7);
            ack_i   = ($urandom_range(0, 9) < 6);
            flush_i = ($urandom_range(0, 9) == 0);
            instr_i = rand_instr();
            pc_i    = $urandom & 32'hFFFFFFFC;
            #1;
            exp_ack = valid_i && (!m_valid || ack_i) && !flush_i;
            chk("rnd_ack", ack_o, exp_ack);
            chk("rnd_valid", valid_o, m_valid);
            if (m_valid) begin
                chk("rnd_pc", pc_o, m_pc);
                chk("rnd_class", class_o, m_ent.cls);
                chk("rnd_imm", imm_o, m_ent.imm);
                chk("rnd_regs", {rd_o, rs1_o, rs2_o}, {m_ent.rd, m_ent.rs1, m_ent.rs2});
                chk("rnd_flags", {we_o, illegal_o, funct3_o, funct7b5_o},
                    {m_ent.we, m_ent.ill, m_ent.f3, m_ent.f7b5});
            end
            @(posedge clk);
            if (flush_i) begin
                m_valid = 0;
            end else if (exp_ack) begin
                m_ent = ref_decode(instr_i, 1'b1);
                m_pc = pc_i;
                m_valid = 1;
                $display("txn rnd pc=%08h instr=%08h class=%0d", pc_i, instr_i, m_ent.cls);
            end else if (ack_i) begin
                m_valid = 0;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction decode stage of the in-order RV32I pipeline, directly downstream of the instruction fetch stage.
- Accepts {instr, pc} over the IF valid/ack handshake and decodes it into register addresses, a sign-extended immediate, an operation class and control bits.
- Holds the result in a single-entry output register for the execute stage, with back-pressure and flush.

Parameters:
- SUPPORT_FENCE, 1, 1: FENCE (opcode 0001111) decodes as class FENCE; 0: FENCE is illegal.

Ports:
- clk  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  discard the held entry and block acceptance this cycle
- valid_i  in  1  IF entry valid
- instr_i  in  32  instruction from IF
- pc_i  in  32  pc of instr_i
- ack_o  out  1  entry consumed this cycle; IF drops valid next cycle
- valid_o  out  1  decoded entry valid toward EX
- ack_i  in  1  EX consumes the current entry
- pc_o  out  32  pc of decoded entry
- rs1_o  out  5  source register 1 (0 when the class does not read rs1)
- rs2_o  out  5  source register 2 (0 when the class does not read rs2)
- rd_o  out  5  destination register
- we_o  out  1  register write enable
- imm_o  out  32  sign-extended immediate
- class_o  out  4  operation class
- funct3_o  out  3  instr[14:12]
- funct7b5_o  out  1  instr[30]
- illegal_o  out  1  instruction is illegal

Behaviour:
- Reset (rst_i=1 at posedge):
  - valid_o=0, all decoded outputs=0, class_o=0.
  - ack_o is 0 while rst_i=1.
- Accept condition (combinational): ack_o = valid_i & (!valid_o | ack_i) & !flush_i & !rst_i.
  - On ack_o, the decoded entry is loaded at the next posedge and valid_o=1. Latency: 1 cycle.
- Drain: ack_i & !ack_o → valid_o=0 next cycle.
- Back-to-back: ack_i & ack_o in the same cycle → new entry replaces the old one and valid_o stays 1. Full throughput is 1 instr/cycle.
- Stall: valid_o & !ack_i → every output is held stable and ack_o=0.
- Flush: flush_i → valid_o=0 next cycle regardless of ack_i/valid_i. Nothing is accepted that cycle.
- Precedence: rst_i > flush_i > accept/drain.
- Class encoding (opcode instr[6:0] → class_o):
  - 0110111 LUI=0, 0010111 AUIPC=1, 1101111 JAL=2, 1100111 JALR=3, 1100011 BRANCH=4
  - 0000011 LOAD=5, 0100011 STORE=6, 0010011 OP_IMM=7, 0110011 OP=8
  - 0001111 FENCE=9, 1110011 SYSTEM=10, illegal=15
- Immediate formats:
  - I (JALR, LOAD, OP_IMM, SYSTEM): {20{i[31]}, i[31:20]}
  - S: {20{i[31]}, i[31:25], i[11:7]}
  - B: {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}
  - U: {i[31:12], 12'b0}
  - J: {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}
  - OP, FENCE, illegal: imm=0
- Register fields:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - we_o = (class ∈ {LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP}) & rd≠0.
  - rd_o = 0 whenever we_o=0.
- Illegal conditions (any of these → class 15, illegal_o=1, we_o=0, rs1/rs2/rd=0):
  - instr[1:0]≠11, or opcode not listed above.
  - JALR with funct3≠0.
  - BRANCH with funct3 ∈ {2,3}.
  - LOAD with funct3 ∈ {3,6,7}.
  - STORE with funct3>2.
  - OP_IMM SLLI with funct7≠0; OP_IMM SRLI/SRAI with funct7 ∉ {0x00,0x20}.
  - OP with funct7 ∉ {0x00,0x20}, or funct7=0x20 with funct3 ∉ {0,5}.
  - FENCE when SUPPORT_FENCE=0.
- An illegal entry still uses the normal handshake: valid_o=1 with its pc, and EX raises the trap.

Test Plan:
- Reset: rst_i=1 with valid_i=1 → ack_o=0, valid_o=0. Release reset, present instr 0x00500093 at pc 0x100 → ack_o=1; next cycle valid_o=1, class 7, rd 1, rs1 0, imm 0x00000005, we_o=1, pc_o 0x100.
- Branch imm: instr 0xFE000EE3 → class 4, imm 0xFFFFFFFC, we_o=0, rd_o=0. Then LUI 0x123452B7 → class 0, rd 5, imm 0x12345000.
- Stall/throughput: 3 back-to-back instrs with ack_i=0 for 2 cycles after the first.
  - Outputs hold the first entry and ack_o=0 during the stall.
  - After ack_i=1 the remaining two issue on consecutive cycles with no bubble.
- Flush: valid_o=1, flush_i=1 with valid_i=1 and ack_i=0 → ack_o=0, valid_o=0 next cycle. The IF entry is accepted the cycle after flush deasserts.
- Illegal: instrs 0x00000000, 0xFFFFFFFF, 0x40001033 (SUB-form with funct3=1) → class 15, illegal_o=1, we_o=0. With SUPPORT_FENCE=0, 0x0000000F → illegal.
- Simultaneous: valid_o=1, ack_i=1, valid_i=1 → ack_o=1 and the new entry appears next cycle with valid_o continuously 1.
